pipe_sequencer: RTL and testbench

Run-control sequencer for the 5-stage pipeline. It turns the divided-clock tick, the PAUSE switch, the debounced STEP pulse and a PC breakpoint into a single-cycle advance strobe (ADV) that enables every pipeline register and the PC. After reset it issues a flush/drain sequence so that stale IF/ID..MEM/WB contents retire as bubbles. It sits between clockdiv/debouncer and the pipeline stage registers, and exposes state and an advance counter for the display path.

---
 rtl/pipe_sequencer_if.sv | 27 ++
 rtl/pipe_sequencer.sv | 108 ++++++++++
 tb/tb_pipe_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_sequencer_if.sv
// Run-control bus between the clock/button front end and the pipeline sequencer.
// The master side owns ticks, switches and addresses; the slave side returns advance strobes and status.
interface pipe_sequencer_if #(
  parameter int CW = 16
);
  logic          TICK;
  logic          PAUSE;
  logic          STEP_DN;
  logic          BP_EN;
  logic [7:0]    BP_ADDR;
  logic [7:0]    PC;
  logic          ADV;
  logic          FLUSH;
  logic          STEP_DONE;
  logic [2:0]    STATE;
  logic [CW-1:0] CYCLES;

  modport master (
    output TICK, PAUSE, STEP_DN, BP_EN, BP_ADDR, PC,
    input  ADV, FLUSH, STEP_DONE, STATE, CYCLES
  );

  modport slave (
    input  TICK, PAUSE, STEP_DN, BP_EN, BP_ADDR, PC,
    output ADV, FLUSH, STEP_DONE, STATE, CYCLES
  );
endinterface

// File: rtl/pipe_sequencer.sv
// Run-control sequencer: turns ticks, pause, single-step and a PC breakpoint into one advance strobe,
// with a post-reset flush drain so stale pipeline contents retire as bubbles.
module pipe_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic            CLK,
  input  logic            RST,
  pipe_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_DRAIN  = 3'd0,
    S_RUN    = 3'd1,
    S_PAUSED = 3'd2,
    S_STEP   = 3'd3,
    S_BREAK  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_FLUSH = 4'(DEPTH - 1);

  state_t        state;
  logic [3:0]    drain_cnt;
  logic          skip;
  logic          adv;
  logic          flush;
  logic          step_done;
  logic [CW-1:0] cycles;

  logic bp_hit;
  assign bp_hit = bus.TICK && bus.BP_EN && (bus.PC == bus.BP_ADDR) && !skip;

  // One registered process holds the state and every output so that ADV,
  // FLUSH and STEP_DONE are single-cycle and line up with the new STATE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_DRAIN;
      drain_cnt <= '0;
      skip      <= 1'b0;
      adv       <= 1'b0;
      flush     <= 1'b0;
      step_done <= 1'b0;
      cycles    <= '0;
    end else begin
      adv       <= 1'b0;
      flush     <= 1'b0;
      step_done <= 1'b0;
      case (state)
        S_DRAIN: begin
          if (bus.TICK) begin
            adv   <= 1'b1;
            flush <= 1'b1;
            if (drain_cnt == LAST_FLUSH) begin
              drain_cnt <= '0;
              skip      <= 1'b1;
              state     <= bus.PAUSE ? S_PAUSED : S_RUN;
            end else begin
              drain_cnt <= drain_cnt + 4'd1;
            end
          end
        end
        S_RUN: begin
          if (bus.PAUSE) begin
            state <= S_PAUSED;
          end else if (bp_hit) begin
            state <= S_BREAK;
          end else if (bus.TICK) begin
            adv  <= 1'b1;
            skip <= 1'b0;
            if (cycles != '1) cycles <= cycles + 1'b1;
          end
        end
        S_PAUSED: begin
          if (bus.STEP_DN) begin
            state <= S_STEP;
          end else if (!bus.PAUSE) begin
            state <= S_RUN;
            skip  <= 1'b1;
          end
        end
        // Entry into STEP is registered after the press, so any tick seen here is strictly later.
        S_STEP: begin
          if (bus.TICK) begin
            adv       <= 1'b1;
            step_done <= 1'b1;
            state     <= bus.PAUSE ? S_PAUSED : S_BREAK;
            if (cycles != '1) cycles <= cycles + 1'b1;
          end
        end
        S_BREAK: begin
          if (bus.STEP_DN) begin
            state <= S_STEP;
          end else if (bus.PAUSE) begin
            state <= S_PAUSED;
          end
        end
        default: state <= S_DRAIN;
      endcase
    end
  end

  assign bus.ADV       = adv;
  assign bus.FLUSH     = flush;
  assign bus.STEP_DONE = step_done;
  assign bus.STATE     = state;
  assign bus.CYCLES    = cycles;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Scoreboard bench for pipe_sequencer: directed run-control scenarios followed by randomized
// ticks, pauses, steps, breakpoints and resets checked against a cycle-level reference model.
module tb_pipe_sequencer;

  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CW) - 1;

  localparam int M_DRAIN  = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_STEP   = 3;
  localparam int M_BREAK  = 4;

  typedef struct {
    bit adv;
    bit flush;
    bit sd;
    int state;
    int cycles;
  } rec_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  rec_t q_cyc[$];
  rec_t q_adv[$];

  pipe_sequencer_if #(.CW(CW)) bus ();

  pipe_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit tick, input bit pause, input bit step,
                               input bit bpen, input logic [7:0] bpaddr, input logic [7:0] pc);
    @(negedge CLK);
    bus.TICK    = tick;
    bus.PAUSE   = pause;
    bus.STEP_DN = step;
    bus.BP_EN   = bpen;
    bus.BP_ADDR = bpaddr;
    bus.PC      = pc;
  endtask

  // One tick followed by three quiet cycles, inputs other than TICK/STEP_DN held.
  task automatic runTick(input bit pause, input bit bpen, input logic [7:0] bpaddr, input logic [7:0] pc);
    applyStimulus(1'b1, pause, 1'b0, bpen, bpaddr, pc);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, pause, 1'b0, bpen, bpaddr, pc);
  endtask

  task automatic doReset();
    #2 RST = 1'b0;
    #1;
    checkOutput("rst_adv", bus.ADV, 0);
    checkOutput("rst_state", bus.STATE, M_DRAIN);
    checkOutput("rst_cycles", bus.CYCLES, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    RST = 1'b1;
  endtask

  // Reference model: behaviour at each clock edge from the run-control rules,
  // counting remaining flushes down rather than drained ones up.
  initial begin
    int  mode;
    int  flushes_left;
    bit  m_skip;
    int  m_cycles;
    rec_t r;
    mode = M_DRAIN; flushes_left = DEPTH; m_skip = 0; m_cycles = 0;
    forever begin
      @(posedge CLK);
      r.adv = 0; r.flush = 0; r.sd = 0;
      if (!RST) begin
        mode = M_DRAIN; flushes_left = DEPTH; m_skip = 0; m_cycles = 0;
      end else if (mode == M_DRAIN) begin
        if (bus.TICK) begin
          r.adv = 1; r.flush = 1;
          flushes_left--;
          if (flushes_left == 0) begin
            mode = bus.PAUSE ? M_PAUSED : M_RUN;
            m_skip = 1;
            flushes_left = DEPTH;
          end
        end
      end else if (mode == M_RUN) begin
        if (bus.PAUSE) mode = M_PAUSED;
        else if (bus.TICK && bus.BP_EN && bus.PC == bus.BP_ADDR && !m_skip) mode = M_BREAK;
        else if (bus.TICK) begin
          r.adv = 1; m_skip = 0;
        end
      end else if (mode == M_PAUSED) begin
        if (bus.STEP_DN) mode = M_STEP;
        else if (!bus.PAUSE) begin
          mode = M_RUN; m_skip = 1;
        end
      end else if (mode == M_STEP) begin
        if (bus.TICK) begin
          r.adv = 1; r.sd = 1;
          mode = bus.PAUSE ? M_PAUSED : M_BREAK;
        end
      end else begin
        if (bus.STEP_DN) mode = M_STEP;
        else if (bus.PAUSE) mode = M_PAUSED;
      end
      if (r.adv && !r.flush && m_cycles < MAXC) m_cycles++;
      r.state  = mode;
      r.cycles = m_cycles;
      q_cyc.push_back(r);
      if (r.adv) q_adv.push_back(r);
    end
  end

  // Monitor: per-cycle status against the model, plus per-advance strobe details.
  initial begin
    rec_t r;
    forever begin
      @(negedge CLK);
      if (q_cyc.size() > 0) begin
        r = q_cyc.pop_front();
        checkOutput("adv", bus.ADV, r.adv);
        checkOutput("state", bus.STATE, r.state);
        checkOutput("cycles", bus.CYCLES, r.cycles);
      end
      if (bus.ADV === 1'b1) begin
        if (q_adv.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_adv: got 1 expected 0 at %0t", $time);
        end else begin
          r = q_adv.pop_front();
          checkOutput("flush", bus.FLUSH, r.flush);
          checkOutput("step_done", bus.STEP_DONE, r.sd);
        end
      end else begin
        checkOutput("flush_idle", bus.FLUSH, 0);
        checkOutput("step_done_idle", bus.STEP_DONE, 0);
      end
    end
  end

  initial begin
    bit t, p, s, be;
    int cnt;
    logic [7:0] pc;
    bus.TICK = 0; bus.PAUSE = 0; bus.STEP_DN = 0; bus.BP_EN = 0; bus.BP_ADDR = 0; bus.PC = 0;
    RST = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    checkOutput("init_state", bus.STATE, M_DRAIN);
    checkOutput("init_cycles", bus.CYCLES, 0);
    checkOutput("init_adv", bus.ADV, 0);
    RST = 1'b1;

    for (int k = 0; k < DEPTH; k++) runTick(1'b0, 1'b0, 8'd0, 8'(k));
    checkOutput("drain_to_run", bus.STATE, M_RUN);
    checkOutput("drain_cycles", bus.CYCLES, 0);
    for (int k = 0; k < 3; k++) runTick(1'b0, 1'b0, 8'd0, 8'(k));
    checkOutput("run3_cycles", bus.CYCLES, 3);

    runTick(1'b0, 1'b1, 8'h05, 8'd3);
    runTick(1'b0, 1'b1, 8'h05, 8'd4);
    runTick(1'b0, 1'b1, 8'h05, 8'd5);
    checkOutput("bp_state", bus.STATE, M_BREAK);
    checkOutput("bp_cycles", bus.CYCLES, 5);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 8'd5);
    runTick(1'b0, 1'b1, 8'h05, 8'd5);
    checkOutput("step_back_to_break", bus.STATE, M_BREAK);
    checkOutput("step_cycles", bus.CYCLES, 6);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 8'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'd5);
    runTick(1'b0, 1'b1, 8'h05, 8'd5);
    checkOutput("skip_run", bus.STATE, M_RUN);
    runTick(1'b0, 1'b1, 8'h05, 8'd5);
    checkOutput("rearm_state", bus.STATE, M_BREAK);
    checkOutput("rearm_cycles", bus.CYCLES, 7);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 8'd6);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'd6);
    runTick(1'b0, 1'b1, 8'h05, 8'd6);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h05, 8'd6);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 8'd6);
    checkOutput("pause_state", bus.STATE, M_PAUSED);
    checkOutput("pause_cycles", bus.CYCLES, 8);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 8'd6);
      runTick(1'b1, 1'b1, 8'h05, 8'd6);
    end
    checkOutput("steps_state", bus.STATE, M_PAUSED);
    checkOutput("steps_cycles", bus.CYCLES, 11);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 8'd6);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 8'd6);
    checkOutput("in_step", bus.STATE, M_STEP);
    doReset();

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    checkOutput("drain_adv_high", bus.ADV, 1);
    doReset();
    for (int k = 0; k < DEPTH; k++) runTick(1'b0, 1'b0, 8'd0, 8'd0);
    for (int k = 0; k < 20; k++) runTick(1'b0, 1'b0, 8'd0, 8'(k));
    checkOutput("sat_cycles", bus.CYCLES, MAXC);

    p = 0; be = 0; cnt = 0; pc = 0;
    for (int i = 0; i < 4000; i++) begin
      t = (cnt == 0);
      if (t) cnt = $urandom_range(1, 5);
      else cnt--;
      if ($urandom_range(0, 15) == 0) p = ~p;
      if ($urandom_range(0, 63) == 0) be = ~be;
      s = ($urandom_range(0, 9) == 0);
      pc = 8'($urandom_range(0, 7));
      applyStimulus(t, p, s, be, 8'h05, pc);
      if ($urandom_range(0, 599) == 0) doReset();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
